four_bit_alu: RTL and testbench
===============================

Name: four_bit_alu

Overview:
- Registered 4-bit ALU: add, subtract, compare, or bitwise AND of two 4-bit operands, selected by a 2-bit opcode.
- Produces a 5-bit result and three magnitude-compare flags.
- Leaf datapath block: one clock, synchronous active-low reset, clock-enable gating.
- Consumers sample outputs one cycle after operands/opcode are presented with enable high.

Parameters:
- None. Operand width is fixed at 4 and result width at 5.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, synchronous, active-low
- enable  input  1  clock enable; outputs update only when high
- S  input  2  opcode: 00 ADD, 01 SUB, 10 CMP, 11 AND
- A  input  4  operand A, unsigned
- B  input  4  operand B, unsigned
- Y  output  5  registered result
- AGB  output  1  registered flag, A > B
- AEB  output  1  registered flag, A == B
- ALB  output  1  registered flag, A < B

Interface (already decided):
- One clock; reset is synchronous and active-low.
- Clock port is clk; reset port is rst_n.

Behaviour:
- All outputs are registered and update on the rising edge of clk; latency is 1 cycle.
- Reset:
  - When rst_n == 0 at a rising edge: Y = 5'b00000, AGB = AEB = ALB = 0.
  - Reset has priority over enable.
  - Reset applied mid-operation discards the pending result.
- Enable:
  - enable == 1 at a rising edge: Y and flags load values computed from current S, A, B.
  - enable == 0 at a rising edge: Y and flags hold their previous values.
- Operations, with A and B unsigned:
  - ADD (00): Y = {1'b0,A} + {1'b0,B}; Y[4] is the carry-out. Range 0..30, no wrap.
  - SUB (01): Y[3:0] = (A − B) mod 16; Y[4] = borrow, i.e. 1 when A < B. Example: 3 − 12 gives Y = 5'b1_0111.
  - CMP (10): Y = {2'b00, AGB_next, AEB_next, ALB_next}.
  - AND (11): Y = {1'b0, A & B}.
- Flags:
  - Computed and registered on every enabled cycle, regardless of opcode.
  - Exactly one of AGB, AEB, ALB is 1 after any enabled cycle.
  - All three are 0 only after reset and before the first enabled cycle.
- No illegal opcodes; all four encodings are defined.
- No X propagation from defined inputs.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants/enum: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_AND = 2'b11.
  - Width constants: DATA_W = 4, RES_W = 5.
- One natural sub-module, alu_compare:
  - Combinational unsigned comparator producing gt/eq/lt from A and B.
  - Instantiated once; its outputs feed both the flag registers and the CMP result mux.
- Adder, subtractor, AND and output registers live in the top module.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with enable = 1, A = 12, B = 3 -> Y = 00000, AGB = AEB = ALB = 0; release -> first enabled edge loads a result.
- Sequence with A = 4'b1100, B = 4'b0011, enable = 1, one edge per step:
  - S = 00 -> Y = 0_1111
  - S = 01 -> Y = 0_1001
  - S = 10 -> Y = 00100
  - S = 11 -> Y = 00000
  - Flags stay AGB = 1, AEB = 0, ALB = 0 throughout.
- Boundaries:
  - ADD A = 15, B = 1 -> Y = 1_0000.
  - ADD A = 15, B = 15 -> Y = 1_1110.
  - SUB A = 3, B = 12 -> Y = 1_0111, ALB = 1.
  - SUB A = 0, B = 0 -> Y = 00000, AEB = 1.
- Enable hold: load ADD 5 + 6 (Y = 01011), then enable = 0 while changing A, B, S for 3 cycles -> Y stays 01011 and flags unchanged.
- CMP equal/less: A = 7, B = 7 -> Y = 00010, AEB = 1; A = 2, B = 9 -> Y = 00001, ALB = 1.
- Exhaustive check: all 16×16×4 input combinations with enable = 1 against a reference model, one-cycle latency; assert flags are one-hot after every enabled cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the four-bit ALU slice.
// No logic, no latency.
// No flow control; constants and types only.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_AND = 2'b11
    } op_e;

endpackage

// File: rtl/four_bit_alu_if.sv
// Operand/opcode/enable bundle in, registered result and flags out.
// Latency is set by the attached ALU (one cycle).
// No backpressure; enable is a plain clock enable, results hold while it is low.
interface four_bit_alu_if;
    import alu_pkg::*;

    logic                enable;
    logic [1:0]          S;
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic [RES_W-1:0]    Y;
    logic                AGB;
    logic                AEB;
    logic                ALB;

    // Requester side: presents operands, consumes results.
    modport master (
        output enable, S, A, B,
        input  Y, AGB, AEB, ALB
    );

    // ALU side: consumes operands, produces results.
    modport slave (
        input  enable, S, A, B,
        output Y, AGB, AEB, ALB
    );

endinterface

// File: rtl/alu_compare.sv
// Unsigned magnitude comparator producing mutually exclusive gt/eq/lt.
// Purely combinational, zero cycles.
// No flow control.
module alu_compare
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              eq,
    output logic              lt
);

    // Exactly one of the three is high for any defined a/b.
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/four_bit_alu.sv
// Registered 4-bit ADD/SUB/CMP/AND with 5-bit result and A>B / A==B / A<B flags.
// One cycle from operands with enable high to registered outputs.
// No backpressure; enable low holds all outputs, synchronous reset clears them.
module four_bit_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    four_bit_alu_if.slave   bus
);

    logic              cmp_gt;
    logic              cmp_eq;
    logic              cmp_lt;
    logic [RES_W-1:0]  sum;
    logic [RES_W-1:0]  diff;
    logic [RES_W-1:0]  y_next;

    logic [RES_W-1:0]  y_q;
    logic              agb_q;
    logic              aeb_q;
    logic              alb_q;

    // Single comparator shared by the flag registers and the CMP result.
    alu_compare u_cmp (
        .a  (bus.A),
        .b  (bus.B),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // Zero-extended arithmetic: bit 4 of the sum is carry-out, bit 4 of the
    // difference wraps to 1 exactly when A < B, which is the borrow.
    always_comb begin
        sum  = {1'b0, bus.A} + {1'b0, bus.B};
        diff = {1'b0, bus.A} - {1'b0, bus.B};
    end

    // Result mux; every opcode encoding is defined.
    always_comb begin
        y_next = '0;
        case (op_e'(bus.S))
            OP_ADD:  y_next = sum;
            OP_SUB:  y_next = diff;
            OP_CMP:  y_next = {2'b00, cmp_gt, cmp_eq, cmp_lt};
            OP_AND:  y_next = {1'b0, bus.A & bus.B};
            default: y_next = '0;
        endcase
    end

    // Output registers: reset wins over enable, enable low holds state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= '0;
            agb_q <= 1'b0;
            aeb_q <= 1'b0;
            alb_q <= 1'b0;
        end else if (bus.enable) begin
            y_q   <= y_next;
            agb_q <= cmp_gt;
            aeb_q <= cmp_eq;
            alb_q <= cmp_lt;
        end
    end

    assign bus.Y   = y_q;
    assign bus.AGB = agb_q;
    assign bus.AEB = aeb_q;
    assign bus.ALB = alb_q;

endmodule

// File: tb/tb_four_bit_alu.sv
// Self-checking bench for four_bit_alu: directed plan cases plus random and exhaustive sweeps.
// Expects one-cycle latency; samples 1 time unit after each rising edge.
// Drives enable and reset directly; the design has no backpressure.
module tb_four_bit_alu;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state: what the outputs should read after the last edge.
    logic [4:0] m_y;
    logic       m_gt, m_eq, m_lt;

    four_bit_alu_if bus ();

    four_bit_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Result computed directly from the operation definitions with integer arithmetic.
    function automatic logic [4:0] ref_y(input int s, input int a, input int b);
        int r;
        case (s)
            0:       r = a + b;
            1:       r = ((a < b) ? 16 : 0) + ((a - b + 16) % 16);
            2:       r = (a > b) ? 4 : ((a == b) ? 2 : 1);
            default: r = a & b;
        endcase
        return r[4:0];
    endfunction

    // Present inputs, take one rising edge, advance the model, settle away from the edge.
    task automatic tick(input bit rst, input bit en, input logic [1:0] s,
                        input logic [3:0] a, input logic [3:0] b);
        rst_n      = ~rst;
        bus.enable = en;
        bus.S      = s;
        bus.A      = a;
        bus.B      = b;
        @(posedge clk);
        #1;
        if (rst) begin
            m_y = '0; m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;
        end else if (en) begin
            m_y  = ref_y(int'(s), int'(a), int'(b));
            m_gt = (a > b);
            m_eq = (a == b);
            m_lt = (a < b);
        end
    endtask

    task automatic test_reset;
        tick(1, 1, 2'b00, 4'd12, 4'd3);
        tick(1, 1, 2'b00, 4'd12, 4'd3);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got Y=%b flags=%b%b%b want Y=00000 flags=000",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
        tick(0, 1, 2'b00, 4'd12, 4'd3);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {5'b01111, 3'b100}) begin
            miscompares++;
            $display("FAIL reset_release: got Y=%b flags=%b%b%b want Y=01111 flags=100",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
    endtask

    task automatic test_sequence;
        logic [4:0] want [4];
        want[0] = 5'b01111; want[1] = 5'b01001; want[2] = 5'b00100; want[3] = 5'b00000;
        for (int s = 0; s < 4; s++) begin
            tick(0, 1, 2'(s), 4'b1100, 4'b0011);
            vectors++;
            if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {want[s], 3'b100}) begin
                miscompares++;
                $display("FAIL sequence_op%0d: got Y=%b flags=%b%b%b want Y=%b flags=100",
                         s, bus.Y, bus.AGB, bus.AEB, bus.ALB, want[s]);
            end
        end
    endtask

    task automatic test_boundaries;
        logic [1:0] s_t [4];
        logic [3:0] a_t [4];
        logic [3:0] b_t [4];
        logic [7:0] w_t [4];
        s_t[0] = 2'b00; a_t[0] = 4'd15; b_t[0] = 4'd1;  w_t[0] = {5'b10000, 3'b100};
        s_t[1] = 2'b00; a_t[1] = 4'd15; b_t[1] = 4'd15; w_t[1] = {5'b11110, 3'b010};
        s_t[2] = 2'b01; a_t[2] = 4'd3;  b_t[2] = 4'd12; w_t[2] = {5'b10111, 3'b001};
        s_t[3] = 2'b01; a_t[3] = 4'd0;  b_t[3] = 4'd0;  w_t[3] = {5'b00000, 3'b010};
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, s_t[i], a_t[i], b_t[i]);
            vectors++;
            if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== w_t[i]) begin
                miscompares++;
                $display("FAIL boundary_%0d: got %b_%b%b%b want %b", i,
                         bus.Y, bus.AGB, bus.AEB, bus.ALB, w_t[i]);
            end
        end
    endtask

    task automatic test_enable_hold;
        tick(0, 1, 2'b00, 4'd5, 4'd6);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {5'b01011, 3'b001}) begin
            miscompares++;
            $display("FAIL hold_load: got Y=%b flags=%b%b%b want Y=01011 flags=001",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            vectors++;
            if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {5'b01011, 3'b001}) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got Y=%b flags=%b%b%b want Y=01011 flags=001",
                         i, bus.Y, bus.AGB, bus.AEB, bus.ALB);
            end
        end
    endtask

    task automatic test_cmp;
        tick(0, 1, 2'b10, 4'd7, 4'd7);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {5'b00010, 3'b010}) begin
            miscompares++;
            $display("FAIL cmp_equal: got Y=%b flags=%b%b%b want Y=00010 flags=010",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
        tick(0, 1, 2'b10, 4'd2, 4'd9);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {5'b00001, 3'b001}) begin
            miscompares++;
            $display("FAIL cmp_less: got Y=%b flags=%b%b%b want Y=00001 flags=001",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
    endtask

    task automatic test_mid_reset;
        tick(0, 1, 2'b00, 4'd9, 4'd9);
        tick(1, 1, 2'b00, 4'd14, 4'd1);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: got Y=%b flags=%b%b%b want all zero",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
        tick(0, 0, 2'b00, 4'd14, 4'd1);
        vectors++;
        if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_then_idle: got Y=%b flags=%b%b%b want all zero",
                     bus.Y, bus.AGB, bus.AEB, bus.ALB);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(19) == 0), ($urandom_range(3) != 0),
                 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            vectors++;
            if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {m_y, m_gt, m_eq, m_lt}) begin
                miscompares++;
                $display("FAIL random_%0d: got %b_%b%b%b want %b_%b%b%b", i,
                         bus.Y, bus.AGB, bus.AEB, bus.ALB, m_y, m_gt, m_eq, m_lt);
            end
        end
    endtask

    task automatic test_exhaustive;
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    tick(0, 1, 2'(s), 4'(a), 4'(b));
                    vectors++;
                    if ({bus.Y, bus.AGB, bus.AEB, bus.ALB} !== {m_y, m_gt, m_eq, m_lt}) begin
                        miscompares++;
                        $display("FAIL exhaustive s=%0d a=%0d b=%0d: got %b_%b%b%b want %b_%b%b%b",
                                 s, a, b, bus.Y, bus.AGB, bus.AEB, bus.ALB, m_y, m_gt, m_eq, m_lt);
                    end
                    vectors++;
                    if ((int'(bus.AGB) + int'(bus.AEB) + int'(bus.ALB)) != 1) begin
                        miscompares++;
                        $display("FAIL onehot s=%0d a=%0d b=%0d: got flags=%b%b%b want exactly one set",
                                 s, a, b, bus.AGB, bus.AEB, bus.ALB);
                    end
                end
            end
        end
    endtask

    // Scenario order: each task leaves the model in step with the DUT.
    initial begin
        rst_n = 1'b0; bus.enable = 1'b0; bus.S = 2'b00; bus.A = 4'd0; bus.B = 4'd0;
        m_y = '0; m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;
        test_reset();
        test_sequence();
        test_boundaries();
        test_enable_hold();
        test_cmp();
        test_mid_reset();
        test_random();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
